ps2_device_tx: RTL and testbench

- PS/2 device-side transmitter. Emulates a keyboard or mouse talking to the Propeller's PS/2 host driver on pins 24-27.
- Device generates the PS/2 clock and shifts out 11-bit frames on open-collector lines.
- Honours host inhibit: the host holding clock low aborts the frame.
- Sits between an on-board HID/scan-code source and the PS2Clk/PS2Data inout pads, or a pmodD pair.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_device_tx_if.sv | 24 ++
 rtl/ps2_phase_timer.sv | 33 +++
 rtl/ps2_device_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_device_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame geometry and frame builder.
// Also intended for reuse by a future device-side receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    BIT_HIGH,
    BIT_LOW,
    TAIL,
    ABORT
  } ps2_tx_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [3:0]  PS2_LAST_BIT   = 4'd10;

  // Bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte handshake and open-collector pad signals of the PS/2 device transmitter.
// master = byte source plus pads, slave = ps2_device_tx.
interface ps2_device_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       aborted;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, aborted
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, aborted
  );
endinterface

// File: rtl/ps2_phase_timer.sv
// 16-bit loadable down-counter; tc_o when it reaches zero, mid_o when it equals mid_val_i.
// The count holds at zero until the next load.
module ps2_phase_timer (
  input  logic        clock,
  input  logic        nres,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic [15:0] mid_val_i,
  output logic        tc_o,
  output logic        mid_o
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!nres) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o  = (cnt_q == 16'd0);
  assign mid_o = (cnt_q == mid_val_i);
endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: generates the PS/2 clock and shifts out 11-bit frames.
// Define PS2_INHIBIT_RETRY_EN to resend an inhibited frame instead of dropping it.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 3200,
  parameter int unsigned IDLE_HOLD   = 4000
) (
  input logic            clock,
  input logic            nres,
  ps2_device_tx_if.slave bus
);
  // state    | meaning
  // IDLE     | tx_ready high, waiting for a byte
  // WAIT_BUS | byte latched, waiting for IDLE_HOLD consecutive idle-bus samples
  // BIT_HIGH | clock released; data set mid-phase, inhibit sampled on last cycle
  // BIT_LOW  | clock driven low; host samples the bit
  // TAIL     | both lines released for one half-period before done
  // ABORT    | host inhibit seen; lines released, aborted pulsed

  localparam logic [15:0] HP_LOAD = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] HP_MID  = 16'(HALF_PERIOD - HALF_PERIOD / 2);
  localparam logic [15:0] IH_LOAD = 16'(IDLE_HOLD - 1);

  ps2_tx_state_t             state_q;
  logic [7:0]                data_q;
  logic [3:0]                idx_q;
  logic                      tx_ready_q, busy_q, done_q, aborted_q, clk_oe_q, data_oe_q;
  logic                      line_idle, tmr_load, tmr_tc, tmr_mid;
  logic [15:0]               tmr_val;
  logic [PS2_FRAME_BITS-1:0] frame;

  assign line_idle = bus.ps2_clk_in & bus.ps2_data_in;
  assign frame     = ps2_frame(data_q);

  // Timer reloads: idle-hold count while not framing, half-period on every phase change.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HP_LOAD;
    case (state_q)
      IDLE, ABORT: begin
        tmr_load = 1'b1;
        tmr_val  = IH_LOAD;
      end
      WAIT_BUS: begin
        if (!line_idle) begin
          tmr_load = 1'b1;
          tmr_val  = IH_LOAD;
        end else begin
          tmr_load = tmr_tc;
        end
      end
      BIT_HIGH, BIT_LOW: tmr_load = tmr_tc;
      default: tmr_load = 1'b0;
    endcase
  end

  ps2_phase_timer u_timer (
    .clock      (clock),
    .nres       (nres),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .mid_val_i  (HP_MID),
    .tc_o       (tmr_tc),
    .mid_o      (tmr_mid)
  );

  always_ff @(posedge clock) begin
    if (!nres) begin
      state_q    <= IDLE;
      data_q     <= 8'd0;
      idx_q      <= 4'd0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q <= 4'd0;
          if (tx_ready_q && bus.tx_valid) begin
            data_q     <= bus.tx_data;
            busy_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= WAIT_BUS;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        WAIT_BUS: begin
          if (line_idle && tmr_tc) begin
            idx_q   <= 4'd0;
            state_q <= BIT_HIGH;
          end
        end
        BIT_HIGH: begin
          if (tmr_mid) begin
            data_oe_q <= ~frame[idx_q];
          end
          if (tmr_tc) begin
            if (!bus.ps2_clk_in) begin
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b0;
              aborted_q <= 1'b1;
              state_q   <= ABORT;
            end else begin
              clk_oe_q <= 1'b1;
              state_q  <= BIT_LOW;
            end
          end
        end
        BIT_LOW: begin
          if (tmr_tc) begin
            clk_oe_q <= 1'b0;
            if (idx_q < PS2_LAST_BIT) begin
              idx_q   <= idx_q + 4'd1;
              state_q <= BIT_HIGH;
            end else begin
              data_oe_q <= 1'b0;
              state_q   <= TAIL;
            end
          end
        end
        TAIL: begin
          if (tmr_tc) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ABORT: begin
`ifdef PS2_INHIBIT_RETRY_EN
          state_q <= WAIT_BUS;
`else
          busy_q  <= 1'b0;
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = tx_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: pads modelled as pulled-up open-collector lines plus a host that
// can hold either line low; captured frames are compared with a bit-list reference.
module tb_ps2_device_tx;
  localparam int HP    = 8;
  localparam int IH    = 20;
  localparam int LIMIT = 2000;

  logic clock = 1'b0;
  logic nres  = 1'b0;
  logic host_clk_low  = 1'b0;
  logic host_data_low = 1'b0;

  ps2_device_tx_if bus ();

  ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_HOLD(IH)) dut (
    .clock (clock),
    .nres  (nres),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.ps2_clk_in  = ~bus.ps2_clk_oe  & ~host_clk_low;
  assign bus.ps2_data_in = ~bus.ps2_data_oe & ~host_data_low;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Host-side view of the wire: data taken when the device pulls the clock low.
  bit   bits_q[$];
  int   rise_q[$];
  int   low_start = 0, width_err = 0, clk_rel_cyc = 0;
  int   done_cnt = 0, done_cyc = 0, abort_cnt = 0, both_cnt = 0;
  logic prev_clk_oe = 1'b0;

  always @(negedge clock) begin
    if (bus.ps2_clk_oe && !prev_clk_oe) begin
      bits_q.push_back(~bus.ps2_data_oe);
      rise_q.push_back(cyc);
      low_start = cyc;
    end
    if (!bus.ps2_clk_oe && prev_clk_oe) begin
      if (cyc - low_start != HP) width_err++;
      clk_rel_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.aborted) abort_cnt++;
    if (bus.done && bus.aborted) both_cnt++;
    prev_clk_oe = bus.ps2_clk_oe;
  end

  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [10:0] captured(input int base);
    logic [10:0] f = 'x;
    for (int i = 0; i < 11; i++)
      if (base + i < bits_q.size()) f[i] = bits_q[base+i];
    return f;
  endfunction

  function automatic int rise_at(input int idx);
    return (idx < rise_q.size()) ? rise_q[idx] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic handshake(input logic [7:0] b);
    int n = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < LIMIT) begin
      tick();
      n++;
    end
    tick();
    bus.tx_valid = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_ready_low", 32'(bus.tx_ready), 32'd0);
  endtask

  task automatic wait_done(input int d0, output int ready_seen);
    int n = 0;
    ready_seen = 0;
    while (done_cnt == d0 && n < LIMIT) begin
      if (bus.tx_ready) ready_seen++;
      tick();
      n++;
    end
    check("done_pulse", done_cnt - d0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, output int base);
    int d0, we0, rs;
    base = bits_q.size();
    d0   = done_cnt;
    we0  = width_err;
    handshake(b);
    wait_done(d0, rs);
    check("ready_low_in_frame", rs, 32'd0);
    check("frame_bits", 32'(captured(base)), 32'(ref_frame(b)));
    check("pulse_count", bits_q.size() - base, 32'd11);
    check("pulse_width", width_err - we0, 32'd0);
    check("done_after_rise", done_cyc - clk_rel_cyc, HP);
    tick();
    check("ready_after_done", 32'(bus.tx_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  b;
    logic [10:0] f;
    int base, d0, a0, we0, n, rs, rel, first_done;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          32'({bus.tx_ready, bus.busy, bus.done, bus.aborted, bus.ps2_clk_oe, bus.ps2_data_oe}),
          32'd0);
    nres = 1'b1;
    tick();
    check("reset_ready_rise", 32'(bus.tx_ready), 32'd1);

    // Known byte: wire order 0,0,0,1,1,1,0,0,0,0,1.
    send_frame(8'h1C, base);
    check("frame_1c_literal", 32'(captured(base)), 32'b10000111000);

    send_frame(8'h00, base);
    f = captured(base);
    check("parity_00", 32'(f[9]), 32'd1);
    send_frame(8'hFF, base);
    f = captured(base);
    check("parity_ff", 32'(f[9]), 32'd1);
    send_frame(8'h01, base);
    f = captured(base);
    check("parity_01", 32'(f[9]), 32'd0);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, base);
    end

    // Host inhibit during the high phase of bit 4.
    b    = 8'($urandom_range(0, 255));
    base = bits_q.size();
    d0   = done_cnt;
    a0   = abort_cnt;
    handshake(b);
    n = 0;
    while (!(bits_q.size() == base + 4 && !bus.ps2_clk_oe) && n < LIMIT) begin
      tick();
      n++;
    end
    check("inhibit_at_bit4", bits_q.size() - base, 32'd4);
    tick();
    host_clk_low = 1'b1;
    n = 0;
    while (abort_cnt == a0 && n < 4 * HP) begin
      tick();
      n++;
    end
    check("abort_pulse", abort_cnt - a0, 32'd1);
    tick();
    check("abort_lines_released", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
`ifdef PS2_INHIBIT_RETRY_EN
    check("retry_busy_kept", 32'(bus.busy), 32'd1);
    repeat (HP) tick();
    rel = cyc;
    host_clk_low = 1'b0;
    wait_done(d0, rs);
    check("retry_ready_low", rs, 32'd0);
    check("retry_frame", 32'(captured(base + 4)), 32'(ref_frame(b)));
    check("retry_start", rise_at(base + 4) - rel, IH + HP);
    check("retry_abort_once", abort_cnt - a0, 32'd1);
    tick();
    check("retry_ready_after_done", 32'(bus.tx_ready), 32'd1);
`else
    check("abort_busy_clear", 32'(bus.busy), 32'd0);
    tick();
    check("abort_ready_back", 32'(bus.tx_ready), 32'd1);
    host_clk_low = 1'b0;
    repeat (IH + 3 * HP) tick();
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_no_more_bits", bits_q.size() - base, 32'd4);
`endif

    // tx_valid held across two back-to-back frames.
    base = bits_q.size();
    d0   = done_cnt;
    bus.tx_data  = 8'hAA;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.busy && n < LIMIT) begin
      tick();
      n++;
    end
    bus.tx_data = 8'h55;
    n = 0;
    while (done_cnt == d0 && n < LIMIT) begin
      tick();
      n++;
    end
    first_done = done_cyc;
    n = 0;
    while (!bus.busy && n < LIMIT) begin
      tick();
      n++;
    end
    bus.tx_valid = 1'b0;
    n = 0;
    while (done_cnt < d0 + 2 && n < LIMIT) begin
      tick();
      n++;
    end
    repeat (IH + 3 * HP) tick();
    check("b2b_done_count", done_cnt - d0, 32'd2);
    check("b2b_bit_count", bits_q.size() - base, 32'd22);
    check("b2b_frame_aa", 32'(captured(base)), 32'(ref_frame(8'hAA)));
    check("b2b_frame_55", 32'(captured(base + 11)), 32'(ref_frame(8'h55)));
    check("b2b_idle_gap", 32'((rise_at(base + 11) - first_done) >= IH), 32'd1);

    // Reset pulse while bit 6 is on the wire.
    b    = 8'($urandom_range(0, 255));
    base = bits_q.size();
    d0   = done_cnt;
    a0   = abort_cnt;
    handshake(b);
    n = 0;
    while (bits_q.size() < base + 7 && n < LIMIT) begin
      tick();
      n++;
    end
    check("rst_at_bit6", bits_q.size() - base, 32'd7);
    nres = 1'b0;
    tick();
    nres = 1'b1;
    check("rst_mid_outputs",
          32'({bus.tx_ready, bus.busy, bus.done, bus.aborted, bus.ps2_clk_oe, bus.ps2_data_oe}),
          32'd0);
    tick();
    check("rst_ready_back", 32'(bus.tx_ready), 32'd1);
    repeat (3 * HP) tick();
    check("rst_no_done", done_cnt - d0, 32'd0);
    check("rst_no_abort", abort_cnt - a0, 32'd0);

    // Host request-to-send: data held low stalls the start.
    b    = 8'($urandom_range(0, 255));
    host_data_low = 1'b1;
    base = bits_q.size();
    d0   = done_cnt;
    we0  = width_err;
    handshake(b);
    repeat (3 * IH) tick();
    check("rts_no_clock", bits_q.size() - base, 32'd0);
    rel = cyc;
    host_data_low = 1'b0;
    wait_done(d0, rs);
    check("rts_start", rise_at(base) - rel, IH + HP);
    check("rts_frame", 32'(captured(base)), 32'(ref_frame(b)));
    check("rts_pulse_width", width_err - we0, 32'd0);

    check("done_abort_exclusive", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
